prefetch_fifo: RTL

PREFETCH_FIFO -- requirements
Module: prefetch_fifo

---
 rtl/prefetch_fifo.sv | 99 +++++++++
 1 files changed

// File: rtl/prefetch_fifo.sv
// Instruction prefetch byte queue: 32-byte circular buffer between the fetch unit and the
// decoder, exposing a 16-byte look-ahead window and sticky limit/page-fault markers.
module prefetch_fifo (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pr_reset,
   input  logic         wr_do,
   input  logic [63:0]  wr_data,
   input  logic [3:0]   wr_length,
   output logic         wr_ready,
   input  logic         signal_limit_do,
   input  logic         signal_pf_do,
   output logic [127:0] window_data,
   output logic [4:0]   window_valid,
   output logic         fault_gp,
   output logic         fault_pf,
   input  logic         accept_do,
   input  logic [3:0]   accept_length,
   output logic         prefetched_accept_do,
   output logic [3:0]   prefetched_accept_length
);

   localparam int DEPTH = 32;

   logic [7:0] mem [DEPTH];
   logic [4:0] rd;
   logic [4:0] wr;
   logic [5:0] cnt;
   logic       limit_pending;
   logic       pf_pending;
   logic       clear;
   logic       wr_ok;
   logic       acc_ok;
   logic [5:0] wr_add;
   logic [5:0] acc_sub;

   function automatic logic [4:0] clamp_window(input logic [5:0] c);
      return (c > 6'd16) ? 5'd16 : c[4:0];
   endfunction

   assign clear        = !rst_n || pr_reset;
   assign wr_ready     = (cnt <= 6'd24);
   assign window_valid = clamp_window(cnt);

   // Once a marker is pending the fetch stream has ended; nothing may follow it.
   assign wr_ok = wr_do && wr_ready && (wr_length != 4'd0) && (wr_length <= 4'd8)
                  && !limit_pending && !pf_pending && !clear;
   assign acc_ok = accept_do && (accept_length != 4'd0)
                   && ({1'b0, accept_length} <= window_valid) && !clear;

   assign prefetched_accept_do     = acc_ok;
   assign prefetched_accept_length = acc_ok ? accept_length : 4'd0;

   assign wr_add  = wr_ok  ? {2'b00, wr_length}     : 6'd0;
   assign acc_sub = acc_ok ? {2'b00, accept_length} : 6'd0;

   assign fault_gp = limit_pending && (cnt == 6'd0);
   assign fault_pf = pf_pending && (cnt == 6'd0) && !limit_pending;

   always_ff @(posedge clk) begin
      if (clear) begin
         rd            <= 5'd0;
         wr            <= 5'd0;
         cnt           <= 6'd0;
         limit_pending <= 1'b0;
         pf_pending    <= 1'b0;
      end else begin
         if (wr_ok)
            wr <= wr + {1'b0, wr_length};
         if (acc_ok)
            rd <= rd + {1'b0, accept_length};
         cnt <= cnt + wr_add - acc_sub;
         // A marker in the same cycle as a write lands behind that write's bytes.
         if (!limit_pending && !pf_pending) begin
            if (signal_limit_do)
               limit_pending <= 1'b1;
            if (signal_pf_do)
               pf_pending <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (wr_ok && (i < int'(wr_length)))
            mem[wr + 5'(i)] <= wr_data[8*i +: 8];
      end
   end

   // Bytes beyond the valid count read as zero so stale buffer contents never leak out.
   always_comb begin
      window_data = '0;
      for (int i = 0; i < 16; i++) begin
         if (i < int'(window_valid))
            window_data[8*i +: 8] = mem[rd + 5'(i)];
      end
   end

endmodule
